event_edge_reporter: RTL and testbench
======================================

Name: event_edge_reporter

Overview:
- Edge-sensitive counterpart to the implicit-sensitivity (@*) combinational event tests.
- Samples N_EV level signals on clk, detects every rising/falling transition, and turns each into a timestamped record.
- Records are buffered in a small FIFO and drained through a valid/ready output.
- Exercises always_ff with async reset, packed structs, a priority encoder and a FIFO in the frontend test suite.

Parameters:
- N_EV, 4, number of monitored event inputs (>=2).
- DEPTH, 4, FIFO depth in records (power of 2, >=2).
- TS_W, 8, timestamp counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ev  input  N_EV  event levels, synchronous to clk.
- rec_valid  output  1  FIFO head holds a record.
- rec_ready  input  1  consumer accepts head this cycle.
- rec_idx  output  $clog2(N_EV)  channel index of head record.
- rec_rise  output  1  1 = rising edge, 0 = falling edge.
- rec_ts  output  TS_W  timestamp of head record.
- count  output  $clog2(DEPTH)+1  records currently stored.
- overflow  output  1  sticky: an edge was lost.

Behaviour:
- Reset (async, immediate): ev_q=0, pend=0, pend_lvl=0, ts=0, FIFO empty, overflow=0.
  - Outputs after reset: rec_valid=0, count=0, rec_idx/rec_rise/rec_ts=0.
  - Because ev_q resets to 0, a channel already high when reset releases is reported as a rising edge at the first posedge.
- ts: free-running, +1 every posedge, wraps 2^TS_W-1 -> 0.
- Edge detection: at each posedge, chg = ev ^ ev_q; then ev_q <= ev.
- Pending set: cand = pend | chg; candidate level per channel is pend_lvl for pend bits, ev for new changes.
- Service rule, one record per cycle:
  - When the FIFO has space, the lowest-index set bit of cand is enqueued as {idx, level, ts}.
  - "Space" means count<DEPTH, or count==DEPTH with a pop (rec_valid&&rec_ready) in the same cycle.
  - The serviced bit is cleared; every other cand bit goes to pend, with its level into pend_lvl.
- Latency: ev changes before posedge k with an empty FIFO and no pend → rec_valid=1 in the cycle after posedge k, with rec_ts = ts value before posedge k.
- Loss: a chg bit on a channel whose pend bit is already set and not serviced this cycle sets overflow=1.
  - The new edge is discarded; pend_lvl keeps the older level.
  - overflow clears only on rst.
- Output handshake:
  - A pop occurs on a posedge with rec_valid&&rec_ready.
  - rec_* hold stable while rec_valid&&!rec_ready.
  - rec_ready while empty has no effect.
- Count:
  - push only → +1; pop only → -1; push and pop together → unchanged.
  - Records stay in FIFO order.
- Reset mid-operation: all queued and pending records are dropped immediately; no record is emitted until a new edge after reset.

Decomposition:
- Package event_edge_pkg:
  - typedef ev_rec_t, struct packed {idx, rise, ts}.
  - Default-parameter localparams IDX_W and CNT_W.
- Sub-module event_fifo: synchronous FIFO of ev_rec_t with DEPTH parameter, push/pop/full/empty/count and the same clk/rst.
- Top level keeps ev_q, pend, pend_lvl, ts, the priority encoder and overflow logic.

Test Plan:
- Single edge: rst, ev=0000, ready=1; ev[2]=1 before posedge with ts=5 → one record idx=2 rise=1 ts=5, rec_valid high exactly 1 cycle, count returns 0.
- Simultaneous edges: ev 0000→0101 at ts=10 with ready=1 → idx=0 rise=1 ts=10, then idx=2 rise=1 ts=11 on consecutive cycles.
- Full plus pending: ready=0, toggle ev[1] at ts=0,2,4,6,8,10 → count=4, pend[1] set after ts=8, overflow=1 after ts=10; then ready=1 → 5 records drained, rise = 1,0,1,0,1.
- Push and pop when full: count=4, ready=1, new edge on ev[3] in the same cycle → count stays 4, the ev[3] record enters at the tail, overflow=0.
- Timestamp wrap: edge at ts=255, next edge at ts=0 → rec_ts 255 then 0.
- Async reset mid-stream: count=3, pend≠0, assert rst between clock edges → rec_valid=0, count=0, overflow=0 immediately; no records after release until a new edge.

Source files
------------

// File: rtl/event_edge_pkg.sv
// event_edge_pkg: shared record type and default sizes for the edge reporter
package event_edge_pkg;
  localparam int N_EV_D = 4;
  localparam int DEPTH_D = 4;
  localparam int TS_W_D = 8;
  localparam int IDX_W = $clog2(N_EV_D);
  localparam int CNT_W = $clog2(DEPTH_D) + 1;
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              rise;
    logic [TS_W_D-1:0] ts;
  } ev_rec_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous record FIFO; head output reads zero while empty
module event_fifo
  import event_edge_pkg::*;
#(
  parameter type T = ev_rec_t,
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_din,
  input  logic          i_pop,
  output T              o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_pop;
  assign w_pop = i_pop && !o_empty;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_count = r_cnt;
  assign o_dout = o_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
endmodule

// File: rtl/event_edge_reporter.sv
// event_edge_reporter: turns level transitions on ev into timestamped records
// drained through a valid/ready FIFO, one record serviced per cycle.
module event_edge_reporter
  import event_edge_pkg::*;
#(
  parameter int N_EV = N_EV_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TS_W = TS_W_D,
  localparam int IW = $clog2(N_EV),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_EV-1:0] ev,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [IW-1:0]   rec_idx,
  output logic            rec_rise,
  output logic [TS_W-1:0] rec_ts,
  output logic [CW-1:0]   count,
  output logic            overflow
);
  typedef struct packed {
    logic [IW-1:0]   idx;
    logic            rise;
    logic [TS_W-1:0] ts;
  } rec_t;
  logic [N_EV-1:0] r_ev_q, r_pend, r_pend_lvl;
  logic [TS_W-1:0] r_ts;
  logic r_ovf;
  logic [N_EV-1:0] w_chg, w_cand, w_lvl, w_svc;
  logic [IW-1:0] w_idx;
  logic w_any, w_full, w_empty, w_pop, w_push, w_lost;
  rec_t w_head, w_rec;
  assign w_chg = ev ^ r_ev_q;
  assign w_cand = r_pend | w_chg;
  assign w_lvl = (r_pend & r_pend_lvl) | (~r_pend & ev);
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = N_EV - 1; i >= 0; i--)
      if (w_cand[i]) begin
        w_idx = IW'(i);
        w_any = 1'b1;
      end
  end
  assign w_pop = rec_valid && rec_ready;
  assign w_push = w_any && (!w_full || w_pop);
  assign w_svc = w_push ? (N_EV'(1) << w_idx) : '0;
  // a fresh edge landing on a still-pending, unserviced channel is dropped
  assign w_lost = |(w_chg & r_pend & ~w_svc);
  assign w_rec = '{idx: w_idx, rise: w_lvl[w_idx], ts: r_ts};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ev_q <= '0;
      r_pend <= '0;
      r_pend_lvl <= '0;
      r_ts <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ev_q <= ev;
      r_pend <= w_cand & ~w_svc;
      r_pend_lvl <= w_lvl;
      r_ts <= r_ts + TS_W'(1);
      r_ovf <= r_ovf | w_lost;
    end
  event_fifo #(.T(rec_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_din(w_rec),
    .i_pop(w_pop),
    .o_dout(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(count)
  );
  assign rec_valid = !w_empty;
  assign rec_idx = w_head.idx;
  assign rec_rise = w_head.rise;
  assign rec_ts = w_head.ts;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_event_edge_reporter.sv
// tb_event_edge_reporter: random plus directed stimulus, queue-based reference
// model feeding a scoreboard that a negedge monitor drains.
module tb_event_edge_reporter;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ev = '0;
  logic rec_ready = 1'b0;
  logic rec_valid, rec_rise, overflow;
  logic [1:0] rec_idx;
  logic [7:0] rec_ts;
  logic [2:0] count;
  typedef struct {int idx; bit rise; int ts;} exp_t;
  exp_t exp_q[$];
  bit m_pv[N];
  bit m_pl[N];
  bit [N-1:0] m_prev = '0;
  bit [7:0] m_ts = '0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  event_edge_reporter dut (
    .clk(clk), .rst(rst), .ev(ev), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_rise(rec_rise), .rec_ts(rec_ts), .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask
  // reference: per-channel pending flag/level, records as a queue, count as a number
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_pv[c] = 0;
        m_pl[c] = 0;
      end
      m_prev = '0;
      m_ts = '0;
      m_cnt = 0;
      m_ovf = 0;
      exp_q.delete();
    end else begin
      automatic bit pop = (m_cnt > 0) && rec_ready;
      automatic int sel = -1;
      for (int c = 0; c < N; c++)
        if (sel < 0 && (m_pv[c] || ev[c] != m_prev[c])) sel = c;
      if (sel >= 0 && (m_cnt < D || pop)) begin
        exp_q.push_back('{sel, m_pv[sel] ? m_pl[sel] : ev[sel], int'(m_ts)});
        m_pv[sel] = 0;
        m_cnt++;
      end else sel = -1;
      for (int c = 0; c < N; c++)
        if (c != sel && ev[c] != m_prev[c]) begin
          if (m_pv[c]) m_ovf = 1;
          else begin
            m_pv[c] = 1;
            m_pl[c] = ev[c];
          end
        end
      if (pop) m_cnt--;
      m_prev = ev;
      m_ts++;
    end
  end
  always @(negedge clk) begin
    chk("valid", int'(rec_valid), int'(m_cnt > 0));
    chk("count", int'(count), m_cnt);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (rec_valid && rec_ready) begin
      if (exp_q.size() == 0) chk("unexpected_record", 1, 0);
      else begin
        automatic exp_t e = exp_q.pop_front();
        chk("rec_idx", int'(rec_idx), e.idx);
        chk("rec_rise", int'(rec_rise), int'(e.rise));
        chk("rec_ts", int'(rec_ts), e.ts);
      end
    end
  end
  task automatic step(input logic [N-1:0] e, input logic r);
    ev = e;
    rec_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(ev, r);
  endtask
  initial begin
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_valid", int'(rec_valid), 0);
    chk("reset_ts", int'(rec_ts), 0);
    idle(4, 1);
    step(4'b0100, 1);
    idle(3, 1);
    step(4'b0000, 1);
    step(4'b0101, 1);
    idle(4, 1);
    step(4'b0000, 1);
    idle(4, 1);
    for (int i = 0; i < 6; i++) begin
      step(ev ^ 4'b0010, 0);
      step(ev, 0);
    end
    chk("full_overflow", int'(overflow), 1);
    idle(8, 1);
    for (int i = 0; i < 4; i++) step(ev ^ 4'b0001, 0);
    step(ev ^ 4'b1000, 1);
    idle(6, 1);
    for (int k = 0; k < 600 && m_ts != 8'd255; k++) step(ev, 1);
    step(ev ^ 4'b1000, 1);
    step(ev ^ 4'b0100, 1);
    idle(4, 1);
    for (int i = 0; i < 1500; i++) begin
      automatic logic [N-1:0] e = ev;
      if ($urandom_range(0, 3) == 0) e ^= N'($urandom_range(1, 15));
      step(e, (i % 64 < 16) ? 1'b0 : 1'($urandom_range(0, 3) != 0));
    end
    step('0, 0);
    step(4'b0011, 0);
    step(4'b0111, 0);
    step(4'b1111, 0);
    step(4'b1110, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", int'(rec_valid), 0);
    chk("async_count", int'(count), 0);
    chk("async_overflow", int'(overflow), 0);
    ev = '0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    idle(5, 1);
    step(4'b1000, 1);
    idle(4, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
